// File: rtl/demux_1to4_buf16.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_buf16
// Purpose  : Buffered 1-to-4 demultiplexer. Steers one source word into one
//            of four single-entry holding slots, each with its own
//            valid/ready drain handshake. Slots drain independently.
// Options  : DEMUX_FLOW_THROUGH_EN - when defined, a full slot that is being
//            popped this cycle can be reloaded in the same cycle (adds a
//            combinational out_ready -> in_ready path).
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_buf16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  localparam int C_SLOTS = 4;

  logic [C_SLOTS-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [C_SLOTS];

  logic               w_room;
  logic               w_accept;
  logic [C_SLOTS-1:0] w_load;
  logic [C_SLOTS-1:0] w_pop;

  // The addressed slot has room if it is empty, or (flow-through) if its
  // current word leaves this very cycle.
`ifdef DEMUX_FLOW_THROUGH_EN
  assign w_room = ~r_valid[in_sel] | out_ready[in_sel];
`else
  assign w_room = ~r_valid[in_sel];
`endif

  // Never advertise room while reset is held, so nothing is taken that the
  // reset is about to discard.
  assign in_ready = rst_n & w_room;
  assign w_accept = in_valid & in_ready;

  // One-hot load strobe for the addressed slot; stray out_ready on an empty
  // slot is masked off by the valid flag.
  assign w_load = {C_SLOTS{w_accept}} & (4'b0001 << in_sel);
  assign w_pop  = r_valid & out_ready;

  // Slot registers: reload wins over pop so a same-cycle pop and reload
  // leaves the slot full with the new word; data is kept after a pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int k = 0; k < C_SLOTS; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < C_SLOTS; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (w_pop[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];

endmodule
`default_nettype wire
